// File: rtl/oport_capture.sv
// Watches a computer's output port and queues every value change into a small FIFO
// for a downstream consumer, counting changes lost while the FIFO is full.
module oport_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         oport,
  input  logic                     enable,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drops,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    DISARMED,
    PRIME,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] last;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  logic change;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // NOTE: every signal assigned here gets a value on every path; a missing default would infer a latch.
  always_comb begin
    change = 1'b0;
    if (state == RUN && enable && oport != last) change = 1'b1;
    full = (count == CW'(DEPTH));
    pop  = m_valid && m_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    push = change && (!full || pop);
    drop = change && full && !pop;
  end

  assign m_valid = (count != '0);

  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= DISARMED;
      last  <= '0;
    end else if (!enable) begin
      state <= DISARMED;
    end else begin
      case (state)
        DISARMED: state <= PRIME;
        PRIME: begin
          last  <= oport;
          state <= RUN;
        end
        RUN:      last  <= oport;
        default:  state <= DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      m_data   <= '0;
      drops    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // m_data is a register so it keeps the last byte shown once the FIFO drains.
      if (push && (count == '0 || (pop && count == CW'(1))))
        m_data <= oport;
      else if (pop && count > CW'(1))
        m_data <= mem[rd_ptr + AW'(1)];

      if (drop) begin
        overflow <= 1'b1;
        if (drops != 8'hFF) drops <= drops + 8'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= oport;
  end

endmodule

// File: tb/tb_oport_capture.sv
// Self-checking bench for oport_capture: a vector table, directed multi-cycle
// sequences, and a randomized run compared against a queue-based reference model.
module tb_oport_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] oport;
  logic             enable;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [3:0]       count;
  logic [7:0]       drops;
  logic             overflow;

  int n_tests = 0;
  int n_fail  = 0;

  oport_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .oport    (oport),
    .enable   (enable),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .count    (count),
    .drops    (drops),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] o;
    logic       en;
    logic       rdy;
    int         cnt;
    logic       vld;
    logic [7:0] dat;
  } vec_t;

  vec_t vt [12];

  // Reference model: the FIFO is a queue, arming is a three-step phase counter.
  logic [7:0] mq [$];
  int         md_phase;
  logic [7:0] md_base;
  int         md_drops;
  logic       md_ovf;
  logic [7:0] md_head;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_edge(input logic [7:0] o, input logic en, input logic rdy);
    oport   = o;
    enable  = en;
    m_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic model_reset();
    mq.delete();
    md_phase = 0;
    md_base  = 8'h00;
    md_drops = 0;
    md_ovf   = 1'b0;
    md_head  = 8'h00;
  endtask

  task automatic model_edge(input logic [7:0] o, input logic en, input logic rdy);
    bit chg;
    chg = (md_phase == 2) && en && (o != md_base);
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    if (chg) begin
      if (mq.size() < DEPTH) mq.push_back(o);
      else begin
        if (md_drops < 255) md_drops++;
        md_ovf = 1'b1;
      end
    end
    if (mq.size() > 0) md_head = mq[0];
    if (!en) md_phase = 0;
    else if (md_phase == 0) md_phase = 1;
    else begin
      md_base  = o;
      md_phase = 2;
    end
  endtask

  initial begin
    logic [7:0] hold;
    reset   = 1'b0;
    oport   = 8'h00;
    enable  = 1'b0;
    m_ready = 1'b0;
    #12;
    check("reset_count", 32'(count), 32'd0);
    check("reset_valid", 32'(m_valid), 32'd0);
    check("reset_data", 32'(m_data), 32'd0);
    check("reset_drops", 32'(drops), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Quiet port: nothing queued
    for (int i = 0; i < 20; i++) drive_edge(8'h00, 1'b1, 1'b0);
    check("quiet_count", 32'(count), 32'd0);
    check("quiet_valid", 32'(m_valid), 32'd0);
    check("quiet_drops", 32'(drops), 32'd0);

    // Vector table: priming latency, change detection, drain, empty pop, disarm
    vt[0]  = '{8'h40, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vt[1]  = '{8'h41, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vt[2]  = '{8'h41, 1'b1, 1'b0, 0, 1'b0, 8'h00};
    vt[3]  = '{8'h01, 1'b1, 1'b0, 1, 1'b1, 8'h01};
    vt[4]  = '{8'h01, 1'b1, 1'b0, 1, 1'b1, 8'h01};
    vt[5]  = '{8'h02, 1'b1, 1'b0, 2, 1'b1, 8'h01};
    vt[6]  = '{8'h05, 1'b1, 1'b0, 3, 1'b1, 8'h01};
    vt[7]  = '{8'h05, 1'b1, 1'b1, 2, 1'b1, 8'h02};
    vt[8]  = '{8'h05, 1'b1, 1'b1, 1, 1'b1, 8'h05};
    vt[9]  = '{8'h05, 1'b1, 1'b1, 0, 1'b0, 8'h05};
    vt[10] = '{8'h05, 1'b1, 1'b1, 0, 1'b0, 8'h05};
    vt[11] = '{8'h07, 1'b0, 1'b0, 0, 1'b0, 8'h05};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_edge(vt[i].o, vt[i].en, vt[i].rdy);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].cnt));
      check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vt[i].vld));
      check($sformatf("vec%0d_data", i), 32'(m_data), 32'(vt[i].dat));
    end

    // Overflow: ten changes into an eight-entry FIFO
    do_reset();
    drive_edge(8'h00, 1'b1, 1'b0);
    drive_edge(8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 10; i++) drive_edge(8'(i), 1'b1, 1'b0);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_drops", 32'(drops), 32'd2);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", 32'(m_data), 32'd1);
    // Push and pop on the same edge while full
    drive_edge(8'h33, 1'b1, 1'b1);
    check("fullpp_count", 32'(count), 32'd8);
    check("fullpp_drops", 32'(drops), 32'd2);
    check("fullpp_head", 32'(m_data), 32'd2);
    // Drop counter saturates
    hold = 8'h33;
    for (int i = 0; i < 300; i++) begin
      hold = (i % 2 == 0) ? 8'h20 : 8'h21;
      drive_edge(hold, 1'b1, 1'b0);
    end
    check("sat_drops", 32'(drops), 32'd255);
    check("sat_count", 32'(count), 32'd8);
    // Drain: values 2..8 then the newest byte at the tail
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d", i), 32'(m_data), (i < 7) ? 32'(i + 2) : 32'h33);
      drive_edge(hold, 1'b1, 1'b1);
    end
    check("drain_valid", 32'(m_valid), 32'd0);
    check("drain_overflow_kept", 32'(overflow), 32'd1);

    // Disarm keeps contents; re-arm primes before pushing again
    do_reset();
    drive_edge(8'h00, 1'b1, 1'b0);
    drive_edge(8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) drive_edge(8'(i), 1'b1, 1'b0);
    drive_edge(8'h03, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_edge((i % 2 == 0) ? 8'hA0 : 8'hA1, 1'b0, 1'b0);
    check("disarm_count", 32'(count), 32'd3);
    drive_edge(8'h09, 1'b1, 1'b0);
    check("rearm1_count", 32'(count), 32'd3);
    drive_edge(8'h0A, 1'b1, 1'b0);
    check("rearm2_count", 32'(count), 32'd3);
    drive_edge(8'h0B, 1'b1, 1'b0);
    check("rearm3_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rearm_drain%0d", i), 32'(m_data), (i < 3) ? 32'(i + 1) : 32'h0B);
      drive_edge(8'h0B, 1'b1, 1'b1);
    end
    check("rearm_empty", 32'(m_valid), 32'd0);

    // Asynchronous reset with five entries queued
    drive_edge(8'h0B, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) drive_edge(8'(8'h50 + i), 1'b1, 1'b0);
    check("pre_async_count", 32'(count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_valid", 32'(m_valid), 32'd0);
    check("async_data", 32'(m_data), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized run against the reference model
    do_reset();
    model_reset();
    for (int seg = 0; seg < 30; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 100; c++) begin
        logic [7:0] o;
        logic       en;
        logic       rdy;
        o   = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
        en  = ($urandom_range(0, 19) != 0);
        rdy = ($urandom_range(0, 99) < rdy_pct);
        drive_edge(o, en, rdy);
        model_edge(o, en, rdy);
        check("rnd_count", 32'(count), 32'(mq.size()));
        check("rnd_valid", 32'(m_valid), 32'(mq.size() > 0));
        check("rnd_data", 32'(m_data), 32'(md_head));
        check("rnd_drops", 32'(drops), 32'(md_drops));
        check("rnd_overflow", 32'(overflow), 32'(md_ovf));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
